// File: rtl/led_scan_ctrl_pkg.sv
// Shared types for the 4-digit LED scan controller:
// state encoding, digit-select constants, digit helpers.
package led_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW,
    GAP
  } state_e;

  typedef logic [1:0] idx_t;

  localparam logic [3:0] SG_OFF = 4'b0000;
  localparam logic [3:0] SG_D1  = 4'b1000;
  localparam logic [3:0] SG_D2  = 4'b0100;
  localparam logic [3:0] SG_D3  = 4'b0010;
  localparam logic [3:0] SG_D4  = 4'b0001;

  function automatic logic [3:0] sg_onehot(
    input idx_t i
  );
    logic [3:0] r;
    unique case (i)
      2'd0: r = SG_D1;
      2'd1: r = SG_D2;
      2'd2: r = SG_D3;
      2'd3: r = SG_D4;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] nib(
    input logic [15:0] d,
    input idx_t        i
  );
    return d[{i, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Requester / display bundle between the two sources
// and the scan controller.
interface led_scan_ctrl_if;

  logic        Req_A;
  logic [15:0] BCD_A;
  logic        Req_B;
  logic [15:0] BCD_B;
  logic        Grant_A;
  logic        Grant_B;
  logic [3:0]  Seg_in;
  logic [3:0]  SG;
  logic        Frame_done;

  modport master (
    output Req_A, BCD_A, Req_B, BCD_B,
    input  Grant_A, Grant_B, Seg_in,
    input  SG, Frame_done
  );

  modport slave (
    input  Req_A, BCD_A, Req_B, BCD_B,
    output Grant_A, Grant_B, Seg_in,
    output SG, Frame_done
  );

endinterface

// File: rtl/led_src_arb.sv
// Frame arbiter: B has priority, A is forced in after
// STARVE consecutive B frames taken while A waited.
module led_src_arb #(
  parameter int STARVE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic load,
  output logic win_a,
  output logic win_b
);

  localparam int SW = $clog2(STARVE + 1);
  localparam logic [SW-1:0] CMAX = SW'(STARVE);

  logic [SW-1:0] cnt_q, cnt_d;
  logic          starved;

  always_comb begin
    starved = (cnt_q == CMAX) & req_a;
    win_b   = req_b & ~starved;
    win_a   = req_a & ~win_b;
    cnt_d   = cnt_q;
    if (load) begin
      if (win_b & req_a)
        cnt_d = (cnt_q == CMAX) ? cnt_q
                                : cnt_q + 1'b1;
      else if (win_a | win_b)
        cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// 4-digit multiplexed display scan sequencer with A/B arbitration.
// Define LED_LZB_EN to enable leading-zero blanking.
module led_scan_ctrl
  import led_disp_pkg::*;
#(
  parameter int DWELL  = 4,
  parameter int BLANK  = 1,
  parameter int STARVE = 4
) (
  input  logic            CP,
  input  logic            nCR,
  led_scan_ctrl_if.slave  bus
);

  localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int TW   = $clog2(MAXV + 1);
  localparam logic [TW-1:0] T_DW = TW'(DWELL - 1);
  localparam logic [TW-1:0] T_BL =
    TW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam bit HAS_GAP = (BLANK > 0);

  state_e        state_q, state_d;
  idx_t          idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    sg_q, sg_d;
  logic [3:0]    seg_q, seg_d;
  logic          ga_q, ga_d;
  logic          gb_q, gb_d;
  logic          fd_q, fd_d;
  logic          win_a, win_b;
  logic          any_req, frame_end;

  function automatic logic lit(
    input idx_t        i,
    input logic [15:0] sh
  );
`ifdef LED_LZB_EN
    logic r;
    unique case (i)
      2'd0: r = 1'b1;
      2'd1: r = |sh[15:4];
      2'd2: r = |sh[15:8];
      2'd3: r = |sh[15:12];
    endcase
    return r;
`else
    return 1'b1 | (^{i, sh} & 1'b0);
`endif
  endfunction

  function automatic logic [3:0] sg_show(
    input idx_t        i,
    input logic [15:0] sh
  );
    return lit(i, sh) ? sg_onehot(i) : SG_OFF;
  endfunction

  led_src_arb #(
    .STARVE (STARVE)
  ) u_arb (
    .clk   (CP),
    .rst_n (nCR),
    .req_a (bus.Req_A),
    .req_b (bus.Req_B),
    .load  (state_q == LOAD),
    .win_a (win_a),
    .win_b (win_b)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_d     = tmr_q;
    shadow_d  = shadow_q;
    sg_d      = sg_q;
    seg_d     = seg_q;
    ga_d      = ga_q;
    gb_d      = gb_q;
    frame_end = 1'b0;
    any_req   = bus.Req_A | bus.Req_B;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = LOAD;
      end
      LOAD: begin
        if (win_a | win_b) begin
          shadow_d = win_b ? bus.BCD_B : bus.BCD_A;
          ga_d     = win_a;
          gb_d     = win_b;
          idx_d    = 2'd0;
          tmr_d    = '0;
          state_d  = SHOW;
          sg_d     = sg_show(2'd0, shadow_d);
          seg_d    = nib(shadow_d, 2'd0);
        end else begin
          state_d = IDLE;
        end
      end
      SHOW: begin
        if (tmr_q == T_DW) begin
          tmr_d = '0;
          if (HAS_GAP) begin
            state_d = GAP;
            sg_d    = SG_OFF;
          end else if (idx_q == 2'd3) begin
            frame_end = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
            sg_d  = sg_show(idx_d, shadow_q);
            seg_d = nib(shadow_q, idx_d);
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == T_BL) begin
          tmr_d = '0;
          if (idx_q == 2'd3) begin
            frame_end = 1'b1;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = SHOW;
            sg_d    = sg_show(idx_d, shadow_q);
            seg_d   = nib(shadow_q, idx_d);
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
    endcase
    if (frame_end) begin
      ga_d    = 1'b0;
      gb_d    = 1'b0;
      sg_d    = SG_OFF;
      idx_d   = 2'd0;
      state_d = any_req ? LOAD : IDLE;
    end
    // pulse is registered, so flag the cycle we are about to enter
    fd_d = (idx_d == 2'd3) &&
           (HAS_GAP ? (state_d == GAP  && tmr_d == T_BL)
                    : (state_d == SHOW && tmr_d == T_DW));
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      tmr_q    <= '0;
      shadow_q <= '0;
      sg_q     <= SG_OFF;
      seg_q    <= 4'd0;
      ga_q     <= 1'b0;
      gb_q     <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      shadow_q <= shadow_d;
      sg_q     <= sg_d;
      seg_q    <= seg_d;
      ga_q     <= ga_d;
      gb_q     <= gb_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.SG         = sg_q;
  assign bus.Seg_in     = seg_q;
  assign bus.Grant_A    = ga_q;
  assign bus.Grant_B    = gb_q;
  assign bus.Frame_done = fd_q;

endmodule
